// File: rtl/tlb_maint_ctrl_pkg.sv
// Shared types and constants for the TLB maintenance sequencer: entry layout,
// op codes and the controller's state encoding.
package tlb_pkg;

    typedef struct packed {
        logic [18:0] vppn;
        logic [9:0]  asid;
        logic        g;
        logic [5:0]  ps;
        logic        e;
        logic        v0;
        logic        d0;
        logic [1:0]  mat0;
        logic [1:0]  plv0;
        logic [19:0] ppn0;
        logic        v1;
        logic        d1;
        logic [1:0]  mat1;
        logic [1:0]  plv1;
        logic [19:0] ppn1;
    } tlb_entry_t;

    localparam logic [2:0] TLB_OP_SRCH = 3'd0;
    localparam logic [2:0] TLB_OP_RD   = 3'd1;
    localparam logic [2:0] TLB_OP_WR   = 3'd2;
    localparam logic [2:0] TLB_OP_FILL = 3'd3;
    localparam logic [2:0] TLB_OP_INV  = 3'd4;

    localparam logic [4:0] INV_OP_MAX = 5'd6;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SRCH_ISS  = 3'd1,
        S_SRCH_WAIT = 3'd2,
        S_RD_CAP    = 3'd3,
        S_WRITE     = 3'd4,
        S_INVAL     = 3'd5,
        S_RESP      = 3'd6
    } state_t;

    // Illegal requests are answered straight away with an INE error and touch no TLB port.
    function automatic logic op_illegal(input logic [2:0] op, input logic [4:0] inv_op);
        return (op > TLB_OP_INV) || ((op == TLB_OP_INV) && (inv_op > INV_OP_MAX));
    endfunction

endpackage

// File: rtl/tlb_maint_ctrl_if.sv
// Commit-side request channel, CSR operands and CSR-side response channel of the
// TLB maintenance sequencer.
interface tlb_maint_ctrl_if #(parameter int TLBNUM = 32);
    import tlb_pkg::*;
    localparam int IW = $clog2(TLBNUM);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
    // valid and its payload stay stable until that edge, ready may depend on state only.
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [4:0]        req_inv_op;
    logic [9:0]        req_inv_asid;
    logic [18:0]       req_inv_vpn;
    logic [IW-1:0]     csr_index;
    logic [18:0]       csr_vppn;
    logic [9:0]        csr_asid;
    tlb_entry_t        csr_entry;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_err;
    logic              rsp_found;
    logic [IW-1:0]     rsp_index;
    tlb_entry_t        rsp_entry;

    modport master (
        output req_valid, req_op, req_inv_op, req_inv_asid, req_inv_vpn,
               csr_index, csr_vppn, csr_asid, csr_entry, rsp_ready,
        input  req_ready, rsp_valid, rsp_err, rsp_found, rsp_index, rsp_entry
    );

    modport slave (
        input  req_valid, req_op, req_inv_op, req_inv_asid, req_inv_vpn,
               csr_index, csr_vppn, csr_asid, csr_entry, rsp_ready,
        output req_ready, rsp_valid, rsp_err, rsp_found, rsp_index, rsp_entry
    );

endinterface

// File: rtl/tlb_maint_ctrl_fill_sel.sv
// Victim index selector for TLBFILL; a plain wrapping counter kept in its own
// module so a pseudo-random selector can replace it without touching the sequencer.
module tlb_fill_sel #(
    parameter  int TLBNUM = 32,
    localparam int IW     = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          advance,
    output logic [IW-1:0] fill_idx
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_idx <= '0;
        end else if (advance) begin
            fill_idx <= (fill_idx == IW'(TLBNUM - 1)) ? '0 : fill_idx + IW'(1);
        end
    end

endmodule

// File: rtl/tlb_maint_ctrl.sv
// TLB maintenance sequencer: takes one op from commit, drives the matching TLB
// array port for one cycle, and holds the result for the CSR unit.
module tlb_maint_ctrl
    import tlb_pkg::*;
#(
    parameter  int TLBNUM = 32,
    localparam int IW     = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          rst_n,
    tlb_maint_ctrl_if.slave bus,
    output logic          s1_fetch,
    output logic [18:0]   s1_vppn,
    output logic          s1_odd_page,
    output logic [9:0]    s1_asid,
    input  logic          s1_found,
    input  logic [4:0]    s1_index,
    output logic [IW-1:0] r_index,
    input  tlb_entry_t    r_entry,
    output logic          we,
    output logic [IW-1:0] w_index,
    output tlb_entry_t    w_entry,
    output logic          inv_en,
    output logic [4:0]    inv_op,
    output logic [9:0]    inv_asid,
    output logic [18:0]   inv_vpn,
    output state_t        dbg_state
);

    state_t        state_q, state_d;
    logic          accept;
    logic [2:0]    op_q;
    logic [4:0]    inv_op_q;
    logic [9:0]    inv_asid_q;
    logic [18:0]   inv_vpn_q;
    logic [IW-1:0] index_q;
    logic [18:0]   vppn_q;
    logic [9:0]    asid_q;
    tlb_entry_t    entry_q;
    logic          rsp_err_q;
    logic          rsp_found_q;
    logic [IW-1:0] rsp_index_q;
    tlb_entry_t    rsp_entry_q;
    logic          fill_adv;
    logic [IW-1:0] fill_idx;

    assign accept = bus.req_valid & bus.req_ready;

    tlb_fill_sel #(.TLBNUM(TLBNUM)) u_fill_sel (
        .clk      (clk),
        .rst_n    (rst_n),
        .advance  (fill_adv),
        .fill_idx (fill_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (op_illegal(bus.req_op, bus.req_inv_op)) begin
                        state_d = S_RESP;
                    end else begin
                        case (bus.req_op)
                            TLB_OP_SRCH: state_d = S_SRCH_ISS;
                            TLB_OP_RD:   state_d = S_RD_CAP;
                            TLB_OP_INV:  state_d = S_INVAL;
                            default:     state_d = S_WRITE;
                        endcase
                    end
                end
            end
            S_SRCH_ISS:  state_d = S_SRCH_WAIT;
            S_SRCH_WAIT: state_d = S_RESP;
            S_RD_CAP:    state_d = S_RESP;
            S_WRITE:     state_d = S_RESP;
            S_INVAL:     state_d = S_RESP;
            S_RESP:      if (bus.rsp_ready) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        s1_fetch      = 1'b0;
        we            = 1'b0;
        inv_en        = 1'b0;
        fill_adv      = 1'b0;
        case (state_q)
            S_IDLE:     bus.req_ready = 1'b1;
            S_SRCH_ISS: s1_fetch      = 1'b1;
            S_WRITE: begin
                we       = 1'b1;
                fill_adv = (op_q == TLB_OP_FILL);
            end
            S_INVAL:    inv_en        = 1'b1;
            S_RESP:     bus.rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Operands are frozen at accept so the CSRs may move while the op is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= '0;
            inv_op_q    <= '0;
            inv_asid_q  <= '0;
            inv_vpn_q   <= '0;
            index_q     <= '0;
            vppn_q      <= '0;
            asid_q      <= '0;
            entry_q     <= '0;
            rsp_err_q   <= 1'b0;
            rsp_found_q <= 1'b0;
            rsp_index_q <= '0;
            rsp_entry_q <= '0;
        end else begin
            if (accept) begin
                op_q        <= bus.req_op;
                inv_op_q    <= bus.req_inv_op;
                inv_asid_q  <= bus.req_inv_asid;
                inv_vpn_q   <= bus.req_inv_vpn;
                index_q     <= bus.csr_index;
                vppn_q      <= bus.csr_vppn;
                asid_q      <= bus.csr_asid;
                entry_q     <= bus.csr_entry;
                rsp_err_q   <= op_illegal(bus.req_op, bus.req_inv_op);
                rsp_found_q <= 1'b0;
            end
            // On a miss the index keeps its old value; only rsp_found carries meaning.
            if (state_q == S_SRCH_WAIT) begin
                rsp_found_q <= s1_found;
                if (s1_found) rsp_index_q <= s1_index[IW-1:0];
            end
            if (state_q == S_RD_CAP) rsp_entry_q <= r_entry;
        end
    end

    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_found = rsp_found_q;
    assign bus.rsp_index = rsp_index_q;
    assign bus.rsp_entry = rsp_entry_q;

    assign s1_vppn     = vppn_q;
    assign s1_asid     = asid_q;
    assign s1_odd_page = 1'b0;
    assign r_index     = index_q;
    assign w_index     = (op_q == TLB_OP_FILL) ? fill_idx : index_q;
    assign w_entry     = entry_q;
    assign inv_op      = inv_op_q;
    assign inv_asid    = inv_asid_q;
    assign inv_vpn     = inv_vpn_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// Self-checking bench for tlb_maint_ctrl: directed scenarios plus randomized ops
// checked against a behavioural model of the TLB array and fill counter.
`timescale 1ns/1ps
module tb_tlb_maint_ctrl;
    import tlb_pkg::*;

    localparam int TLBNUM = 32;
    localparam int IW     = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tlb_maint_ctrl_if #(.TLBNUM(TLBNUM)) bus ();

    logic          s1_fetch, s1_odd_page;
    logic [18:0]   s1_vppn;
    logic [9:0]    s1_asid;
    logic          s1_found = 1'b0;
    logic [4:0]    s1_index = 5'd0;
    logic [IW-1:0] r_index, w_index;
    tlb_entry_t    r_entry, w_entry;
    logic          we, inv_en;
    logic [4:0]    inv_op;
    logic [9:0]    inv_asid;
    logic [18:0]   inv_vpn;
    state_t        dbg_state;

    tlb_maint_ctrl #(.TLBNUM(TLBNUM)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .s1_fetch(s1_fetch), .s1_vppn(s1_vppn), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
        .s1_found(s1_found), .s1_index(s1_index),
        .r_index(r_index), .r_entry(r_entry),
        .we(we), .w_index(w_index), .w_entry(w_entry),
        .inv_en(inv_en), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vpn(inv_vpn),
        .dbg_state(dbg_state)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural TLB array: combinational read, write on strobe, registered search result.
    tlb_entry_t    mem [TLBNUM];
    assign r_entry = mem[r_index];
    logic          cfg_found;
    logic [4:0]    cfg_idx;
    int            n_fetch, n_we, n_inv, excl_viol;
    logic [18:0]   seen_vppn;
    logic [9:0]    seen_asid;
    logic          seen_odd;
    logic [IW-1:0] seen_widx, seen_ridx;
    tlb_entry_t    seen_wentry;
    logic [4:0]    seen_iop;
    logic [9:0]    seen_iasid;
    logic [18:0]   seen_ivpn;

    // Reference state: next FILL victim and the last search-hit index.
    int            model_fill;
    logic [IW-1:0] model_rsp_index;

    always @(posedge clk) begin
        if (int'(s1_fetch) + int'(we) + int'(inv_en) > 1) excl_viol++;
        if (s1_fetch) begin
            n_fetch++;
            seen_vppn = s1_vppn; seen_asid = s1_asid; seen_odd = s1_odd_page;
            s1_found <= cfg_found;
            s1_index <= cfg_idx;
        end
        if (we) begin
            n_we++;
            seen_widx = w_index; seen_wentry = w_entry;
            mem[w_index] = w_entry;
        end
        if (inv_en) begin
            n_inv++;
            seen_iop = inv_op; seen_iasid = inv_asid; seen_ivpn = inv_vpn;
        end
        if (dbg_state == S_RD_CAP) seen_ridx = r_index;
    end

    function automatic tlb_entry_t rand_entry();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[88:0];
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [4:0] iop);
        if (op >= 3'd5 || (op == 3'd4 && iop > 5'd6)) return 0;
        if (op == 3'd0) return 2;
        return 1;
    endfunction

    // Drives one op through accept and response; stall holds rsp_ready low while a
    // second request is offered, and stall_ok records whether everything held still.
    task automatic issue(input logic [2:0] op, input logic [4:0] iop, input int stall,
                         output int lat, output logic err, output logic found,
                         output logic [IW-1:0] idx, output tlb_entry_t ent, output logic stall_ok);
        int guard;
        lat = -1; err = 1'bx; found = 1'bx; idx = 'x; ent = 'x; stall_ok = 1'b0;
        @(negedge clk);
        n_fetch = 0; n_we = 0; n_inv = 0;
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_inv_op = iop;
        guard = 0;
        while (!bus.req_ready && guard < 50) begin @(negedge clk); guard++; end
        if (!bus.req_ready) begin
            n_cmp++; n_fail++;
            $display("FAIL accept_timeout op=%0d req_ready=%b required=1", op, bus.req_ready);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin @(negedge clk); lat++; end
        err = bus.rsp_err; found = bus.rsp_found; idx = bus.rsp_index; ent = bus.rsp_entry;
        stall_ok = 1'b1;
        for (int i = 0; i < stall; i++) begin
            bus.req_valid = 1'b1;
            @(negedge clk);
            if (bus.req_ready || !bus.rsp_valid || bus.rsp_err !== err || bus.rsp_found !== found ||
                bus.rsp_index !== idx || bus.rsp_entry !== ent || dbg_state !== S_RESP)
                stall_ok = 1'b0;
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < TLBNUM; i++) mem[i] = rand_entry();
        cfg_found = 1'b0; cfg_idx = 5'd0;
        bus.req_valid = 1'b0; bus.rsp_ready = 1'b0; bus.req_op = '0; bus.req_inv_op = '0;
        bus.req_inv_asid = '0; bus.req_inv_vpn = '0; bus.csr_index = '0; bus.csr_vppn = '0;
        bus.csr_asid = '0; bus.csr_entry = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({s1_fetch, we, inv_en} !== 3'b000) begin
            n_fail++; $display("FAIL reset_strobes got=%b required=000", {s1_fetch, we, inv_en});
        end
        n_cmp++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_found, bus.rsp_index} !== '0 || bus.rsp_entry !== '0) begin
            n_fail++; $display("FAIL reset_rsp got v=%b e=%b f=%b i=%0d required all 0",
                               bus.rsp_valid, bus.rsp_err, bus.rsp_found, bus.rsp_index);
        end
        n_cmp++;
        if (s1_vppn !== '0 || s1_asid !== '0 || r_index !== '0 || w_index !== '0 || w_entry !== '0 ||
            inv_op !== '0 || inv_asid !== '0 || inv_vpn !== '0) begin
            n_fail++; $display("FAIL reset_data got w_index=%0d s1_vppn=%h inv_vpn=%h required 0",
                               w_index, s1_vppn, inv_vpn);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 1'b1 || dbg_state !== S_IDLE) begin
            n_fail++; $display("FAIL reset_idle got req_ready=%b state=%0d required 1/IDLE",
                               bus.req_ready, dbg_state);
        end
        model_fill = 0; model_rsp_index = '0;
    endtask

    task automatic test_srch();
        int lat; logic err, found, sok; logic [IW-1:0] idx; tlb_entry_t ent;
        bus.csr_vppn = 19'h12345; bus.csr_asid = 10'd5;
        cfg_found = 1'b1; cfg_idx = 5'd7;
        issue(TLB_OP_SRCH, 5'd0, 0, lat, err, found, idx, ent, sok);
        model_rsp_index = 5'd7;
        n_cmp++;
        if (lat !== 2) begin n_fail++; $display("FAIL srch_latency got=%0d required=2", lat); end
        n_cmp++;
        if ({err, found} !== 2'b01 || idx !== 5'd7) begin
            n_fail++; $display("FAIL srch_hit got err=%b found=%b idx=%0d required 0/1/7", err, found, idx);
        end
        n_cmp++;
        if (n_fetch !== 1 || n_we !== 0 || n_inv !== 0) begin
            n_fail++; $display("FAIL srch_strobes got fetch=%0d we=%0d inv=%0d required 1/0/0", n_fetch, n_we, n_inv);
        end
        n_cmp++;
        if (seen_vppn !== 19'h12345 || seen_asid !== 10'd5 || seen_odd !== 1'b0) begin
            n_fail++; $display("FAIL srch_key got vppn=%h asid=%0d odd=%b required 12345/5/0", seen_vppn, seen_asid, seen_odd);
        end
        cfg_found = 1'b0; cfg_idx = 5'd12;
        issue(TLB_OP_SRCH, 5'd0, 0, lat, err, found, idx, ent, sok);
        n_cmp++;
        if (found !== 1'b0 || idx !== model_rsp_index) begin
            n_fail++; $display("FAIL srch_miss got found=%b idx=%0d required 0/%0d", found, idx, model_rsp_index);
        end
    endtask

    task automatic test_rd();
        int lat; logic err, found, sok; logic [IW-1:0] idx; tlb_entry_t ent, exp_ent;
        mem[3].ppn0 = 20'hABCDE;
        exp_ent = mem[3];
        bus.csr_index = 5'd3;
        issue(TLB_OP_RD, 5'd0, 0, lat, err, found, idx, ent, sok);
        n_cmp++;
        if (lat !== 1) begin n_fail++; $display("FAIL rd_latency got=%0d required=1", lat); end
        n_cmp++;
        if (seen_ridx !== 5'd3) begin n_fail++; $display("FAIL rd_index got=%0d required=3", seen_ridx); end
        n_cmp++;
        if (ent !== exp_ent || ent.ppn0 !== 20'hABCDE || err !== 1'b0) begin
            n_fail++; $display("FAIL rd_entry got=%h required=%h err=%b", ent, exp_ent, err);
        end
    endtask

    task automatic test_fill_wr();
        logic [2:0] ops [6] = '{TLB_OP_FILL, TLB_OP_FILL, TLB_OP_FILL, TLB_OP_FILL, TLB_OP_WR, TLB_OP_FILL};
        int lat; logic err, found, sok; logic [IW-1:0] idx, exp_idx; tlb_entry_t ent, exp_ent;
        for (int k = 0; k < 6; k++) begin
            exp_ent = rand_entry();
            bus.csr_entry = exp_ent;
            bus.csr_index = 5'd9;
            exp_idx = (ops[k] == TLB_OP_FILL) ? IW'(model_fill) : 5'd9;
            issue(ops[k], 5'd0, 0, lat, err, found, idx, ent, sok);
            if (ops[k] == TLB_OP_FILL) model_fill = (model_fill + 1) % TLBNUM;
            n_cmp++;
            if (n_we !== 1 || n_fetch !== 0 || n_inv !== 0 || lat !== 1) begin
                n_fail++; $display("FAIL write_pulse step=%0d got we=%0d lat=%0d required 1/1", k, n_we, lat);
            end
            n_cmp++;
            if (seen_widx !== exp_idx || seen_wentry !== exp_ent) begin
                n_fail++; $display("FAIL write_index step=%0d got=%0d required=%0d", k, seen_widx, exp_idx);
            end
        end
    endtask

    task automatic test_inv();
        int lat; logic err, found, sok; logic [IW-1:0] idx; tlb_entry_t ent;
        bus.req_inv_asid = 10'd2; bus.req_inv_vpn = 19'h00100;
        issue(TLB_OP_INV, 5'd5, 0, lat, err, found, idx, ent, sok);
        n_cmp++;
        if (n_inv !== 1 || n_we !== 0 || n_fetch !== 0 || err !== 1'b0 || lat !== 1) begin
            n_fail++; $display("FAIL inv_pulse got inv=%0d err=%b lat=%0d required 1/0/1", n_inv, err, lat);
        end
        n_cmp++;
        if (seen_iop !== 5'd5 || seen_iasid !== 10'd2 || seen_ivpn !== 19'h00100) begin
            n_fail++; $display("FAIL inv_operands got op=%0d asid=%0d vpn=%h required 5/2/00100", seen_iop, seen_iasid, seen_ivpn);
        end
        issue(TLB_OP_INV, 5'd7, 0, lat, err, found, idx, ent, sok);
        n_cmp++;
        if (n_inv !== 0 || err !== 1'b1 || lat !== 0) begin
            n_fail++; $display("FAIL inv_illegal got inv=%0d err=%b lat=%0d required 0/1/0", n_inv, err, lat);
        end
        issue(3'd6, 5'd0, 0, lat, err, found, idx, ent, sok);
        n_cmp++;
        if (n_inv + n_we + n_fetch !== 0 || err !== 1'b1 || lat !== 0) begin
            n_fail++; $display("FAIL op_illegal got strobes=%0d err=%b lat=%0d required 0/1/0", n_inv + n_we + n_fetch, err, lat);
        end
    endtask

    task automatic test_stall();
        int lat; logic err, found, sok; logic [IW-1:0] idx; tlb_entry_t ent;
        cfg_found = 1'b1; cfg_idx = 5'd21;
        issue(TLB_OP_SRCH, 5'd0, 5, lat, err, found, idx, ent, sok);
        model_rsp_index = 5'd21;
        n_cmp++;
        if (sok !== 1'b1 || n_fetch !== 1) begin
            n_fail++; $display("FAIL stall_hold got stable=%b fetch=%0d required 1/1", sok, n_fetch);
        end
        n_cmp++;
        if (found !== 1'b1 || idx !== 5'd21) begin
            n_fail++; $display("FAIL stall_result got found=%b idx=%0d required 1/21", found, idx);
        end
    endtask

    task automatic test_random();
        int lat; logic err, found, sok; logic [IW-1:0] idx, exp_widx; tlb_entry_t ent, exp_ent;
        logic [2:0] op; logic [4:0] iop; logic ill; int stall;
        for (int k = 0; k < 40; k++) begin
            op = 3'($urandom_range(0, 7));
            iop = 5'($urandom_range(0, 9));
            ill = (op >= 3'd5) || (op == 3'd4 && iop > 5'd6);
            bus.csr_index = IW'($urandom_range(0, TLBNUM - 1));
            bus.csr_vppn = 19'($urandom()); bus.csr_asid = 10'($urandom());
            bus.csr_entry = rand_entry();
            bus.req_inv_asid = 10'($urandom()); bus.req_inv_vpn = 19'($urandom());
            cfg_found = 1'($urandom_range(0, 1)); cfg_idx = 5'($urandom_range(0, 31));
            stall = $urandom_range(0, 2);
            exp_ent = mem[bus.csr_index];
            exp_widx = (op == TLB_OP_FILL) ? IW'(model_fill) : bus.csr_index;
            issue(op, iop, stall, lat, err, found, idx, ent, sok);
            n_cmp++;
            if (lat !== exp_lat(op, iop) || err !== ill || sok !== 1'b1) begin
                n_fail++; $display("FAIL rnd_resp k=%0d op=%0d got lat=%0d err=%b stable=%b required %0d/%b/1",
                                   k, op, lat, err, sok, exp_lat(op, iop), ill);
            end
            n_cmp++;
            if (n_fetch !== int'(op == 3'd0) || n_we !== int'(op == 3'd2 || op == 3'd3) ||
                n_inv !== int'(op == 3'd4 && !ill)) begin
                n_fail++; $display("FAIL rnd_strobes k=%0d op=%0d got fetch=%0d we=%0d inv=%0d", k, op, n_fetch, n_we, n_inv);
            end
            if (op == 3'd0) begin
                if (cfg_found) model_rsp_index = cfg_idx;
                n_cmp++;
                if (found !== cfg_found || idx !== model_rsp_index || seen_vppn !== bus.csr_vppn || seen_asid !== bus.csr_asid) begin
                    n_fail++; $display("FAIL rnd_srch k=%0d got found=%b idx=%0d required %b/%0d", k, found, idx, cfg_found, model_rsp_index);
                end
            end else if (op == 3'd1) begin
                n_cmp++;
                if (ent !== exp_ent) begin n_fail++; $display("FAIL rnd_rd k=%0d got=%h required=%h", k, ent, exp_ent); end
            end else if (op == 3'd2 || op == 3'd3) begin
                if (op == 3'd3) model_fill = (model_fill + 1) % TLBNUM;
                n_cmp++;
                if (seen_widx !== exp_widx || seen_wentry !== bus.csr_entry) begin
                    n_fail++; $display("FAIL rnd_write k=%0d got idx=%0d required=%0d", k, seen_widx, exp_widx);
                end
            end else if (op == 3'd4 && !ill) begin
                n_cmp++;
                if (seen_iop !== iop || seen_iasid !== bus.req_inv_asid || seen_ivpn !== bus.req_inv_vpn) begin
                    n_fail++; $display("FAIL rnd_inv k=%0d got op=%0d required=%0d", k, seen_iop, iop);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat, guard; logic err, found, sok; logic [IW-1:0] idx; tlb_entry_t ent;
        issue(TLB_OP_FILL, 5'd0, 0, lat, err, found, idx, ent, sok);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = TLB_OP_SRCH;
        guard = 0;
        while (!bus.req_ready && guard < 50) begin @(negedge clk); guard++; end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (dbg_state !== S_SRCH_WAIT) begin
            n_fail++; $display("FAIL rstmid_reach got state=%0d required=%0d", dbg_state, S_SRCH_WAIT);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({s1_fetch, we, inv_en, bus.rsp_valid} !== 4'b0000) begin
            n_fail++; $display("FAIL rstmid_outputs got=%b required=0000", {s1_fetch, we, inv_en, bus.rsp_valid});
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_fill = 0; model_rsp_index = '0;
        #1;
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got=%b required=1", bus.req_ready); end
        issue(TLB_OP_FILL, 5'd0, 0, lat, err, found, idx, ent, sok);
        n_cmp++;
        if (seen_widx !== IW'(model_fill) || n_we !== 1) begin
            n_fail++; $display("FAIL rstmid_fill got idx=%0d we=%0d required %0d/1", seen_widx, n_we, model_fill);
        end
        n_cmp++;
        if (excl_viol !== 0) begin n_fail++; $display("FAIL strobe_exclusive got=%0d required=0", excl_viol); end
    endtask

    initial begin
        excl_viol = 0;
        test_reset();
        test_srch();
        test_rd();
        test_fill_wr();
        test_inv();
        test_stall();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t required finish before 200000", $time);
        $fatal(1, "timeout");
    end

endmodule
